instr_fetch_unit: RTL and testbench

//   Instruction fetch stage of the multi-cycle RV32I core. Holds the PC and IR registers.

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage of the multi-cycle RV32I core.
// Holds the PC and IR registers. Runs the IR_Write/PC_Write fetch commands from the
// control unit against a variable-latency instruction memory (req/ready handshake).
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   IR_Write, PC_Write      fetch start pulse / increment-pc-on-completion flag
//   pc_load, pc_load_val    jump/branch PC load (honoured in IDLE and ERR only)
//   imem_req, imem_addr     memory request (held until ready) and fetch address (= pc)
//   imem_rdata, imem_ready  instruction word and same-cycle accept/return strobe
//   pc, ir                  architectural PC and instruction register
//   fetch_done              1-cycle pulse in the cycle after ir is written
//   fetch_busy, fetch_err   state != IDLE / state == ERR
module instr_fetch_unit #(
    parameter int unsigned XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            IR_Write,
    input  logic            PC_Write,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_load_val,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ir,
    output logic            fetch_done,
    output logic            fetch_busy,
    output logic            fetch_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]  NOP      = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inc_q, inc_d;
    logic               done_q, done_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               load_misaligned;

    assign load_misaligned = pc_load && (pc_load_val[1:0] != 2'b00);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        inc_d   = inc_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                // A load applies before a fetch so the request goes out at the new pc;
                // a misaligned load wins and suppresses the fetch.
                if (load_misaligned) begin
                    state_d = S_ERR;
                end else begin
                    if (pc_load) begin
                        pc_d    = pc_load_val;
                        state_d = S_IDLE;
                    end
                    if (IR_Write) begin
                        inc_d   = PC_Write;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    if (inc_q) begin
                        pc_d = pc_q + XLEN'(4);
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        err_d  = (state_d == S_ERR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            done_q  <= done_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign fetch_done = done_q;
    assign fetch_busy = busy_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetch tasks push the expected {ir, pc} and a
// monitor pops/compares on every fetch_done pulse. A small memory responder models latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IR_Write, PC_Write, pc_load;
    logic [31:0] pc_load_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc, ir;
    logic        fetch_done, fetch_busy, fetch_err;

    int tests  = 0;
    int errors = 0;

    int          mem_delay = 0;     // REQ cycles before ready; >= 1000 means never
    int          mem_wcnt  = 0;
    logic [31:0] mem_data  = '0;

    logic [63:0] exp_q[$];

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .IR_Write(IR_Write), .PC_Write(PC_Write),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .pc(pc), .ir(ir),
        .fetch_done(fetch_done), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready rises after mem_delay wait cycles of a held request
    always @(negedge clk) begin
        imem_rdata = mem_data;
        if (imem_req) begin
            imem_ready = (mem_wcnt == mem_delay);
            mem_wcnt++;
        end else begin
            imem_ready = 1'b0;
            mem_wcnt   = 0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (fetch_done) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_done: got ir=%h pc=%h expected no pulse", ir, pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_ir", ir, e[63:32]);
                check("sb_pc", pc, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a fetch (optionally with a same-cycle pc_load) and follow it to done/err
    task automatic do_fetch(input logic inc, input logic ld, input logic [31:0] ld_val,
                            input int dly, input logic [31:0] data,
                            input logic [31:0] exp_addr, input int exp_req, input logic exp_err,
                            input logic [31:0] exp_ir, input logic [31:0] exp_pc);
        int   reqs = 0;
        int   busys = 0;
        logic addr_ok = 1'b1;
        logic ended = 1'b0;
        mem_delay = dly;
        mem_data  = data;
        if (!exp_err) exp_q.push_back({exp_ir, exp_pc});
        IR_Write = 1'b1; PC_Write = inc; pc_load = ld; pc_load_val = ld_val;
        step();
        IR_Write = 1'b0; PC_Write = 1'b0; pc_load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (fetch_done || fetch_err) begin
                ended = 1'b1;
                break;
            end
            if (imem_req) reqs++;
            if (fetch_busy) busys++;
            if (imem_addr !== exp_addr) addr_ok = 1'b0;
            step();
        end
        check("fetch_ended", 32'(ended), 32'd1);
        check("req_cycles", 32'(reqs), 32'(exp_req));
        check("busy_cycles", 32'(busys), 32'(exp_req));
        check("addr_stable", 32'(addr_ok), 32'd1);
        check("err_flag", 32'(fetch_err), 32'(exp_err));
        check("req_after", 32'(imem_req), 32'd0);
        check("ir_after", ir, exp_ir);
        check("pc_after", pc, exp_pc);
        step();
        check("done_single", 32'(fetch_done), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] val);
        pc_load = 1'b1; pc_load_val = val;
        step();
        pc_load = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; IR_Write = 1'b0; PC_Write = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // 1: zero-wait fetch with increment
        do_fetch(1'b1, 1'b0, '0, 0, 32'h0050_0093, 32'h0, 1, 1'b0, 32'h0050_0093, 32'h4);
        // 2: three wait states
        do_fetch(1'b1, 1'b0, '0, 3, 32'h0020_81B3, 32'h4, 4, 1'b0, 32'h0020_81B3, 32'h8);
        // 3: memory never answers -> timeout, pc/ir unchanged; then retry succeeds
        do_fetch(1'b1, 1'b0, '0, 1000, 32'hDEAD_BEEF, 32'h8, 15, 1'b1, 32'h0020_81B3, 32'h8);
        check("err_busy", 32'(fetch_busy), 32'd1);
        do_fetch(1'b1, 1'b0, '0, 0, 32'h0000_0513, 32'h8, 1, 1'b0, 32'h0000_0513, 32'hC);
        // 4: load + fetch together uses the new pc; misaligned load errors, pc kept
        do_fetch(1'b1, 1'b1, 32'h100, 0, 32'h0010_0113, 32'h100, 1, 1'b0, 32'h0010_0113, 32'h104);
        do_load(32'h102);
        check("misal_err", 32'(fetch_err), 32'd1);
        check("misal_pc", pc, 32'h104);
        check("misal_req", 32'(imem_req), 32'd0);
        // Aligned load recovers from ERR
        do_load(32'hFFFF_FFFC);
        check("recover_err", 32'(fetch_err), 32'd0);
        check("recover_busy", 32'(fetch_busy), 32'd0);
        check("recover_pc", pc, 32'hFFFF_FFFC);
        // 5: wrap to zero, then a non-incrementing fetch
        do_fetch(1'b1, 1'b0, '0, 0, 32'h0000_0033, 32'hFFFF_FFFC, 1, 1'b0, 32'h0000_0033, 32'h0);
        do_fetch(1'b0, 1'b0, '0, 1, 32'h0000_006F, 32'h0, 2, 1'b0, 32'h0000_006F, 32'h0);
        // 6: reset in the second REQ cycle abandons the fetch
        do_load(32'h200);
        mem_delay = 1000;
        IR_Write = 1'b1; PC_Write = 1'b1;
        step();
        IR_Write = 1'b0; PC_Write = 1'b0;
        check("t6_req1", 32'(imem_req), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        check("t6_pc", pc, 32'h0);
        check("t6_ir", ir, 32'h0000_0013);
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_done", 32'(fetch_done), 32'd0);
        check("t6_busy", 32'(fetch_busy), 32'd0);
        rst_n = 1'b1;
        step(); step(); step();
        check("t6_idle_req", 32'(imem_req), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
